// File: rtl/vga_frame_capture.sv
// vga_frame_capture: recovers raster position from VGA sync edges
// and writes one complete visible frame into a frame-buffer port.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_START  = 144,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_START  = 35,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [7:0]        rgb,
  input  logic              start,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err
);

  localparam logic [10:0] HS0 = 11'(H_START);
  localparam logic [10:0] HE  = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] HL  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VS0 = 10'(V_START);
  localparam logic [9:0]  VE  = 10'(V_START + V_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE, ARMED, CAPTURE, DONE
  } state_t;

  state_t      state, state_n;
  logic        prev_hs, prev_vs;
  logic [10:0] h_cnt, h_nxt;
  logic [9:0]  v_cnt, v_nxt;
  logic        hs_fall, vs_fall;
  logic        vis, last_wr, wr_en_n;

  assign hs_fall = pix_en & prev_hs & ~h_sync;
  assign vs_fall = pix_en & prev_vs & ~v_sync;
  assign last_wr = wr_en && (wr_addr == LAST);

  // raster counters as they will be after this sample
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_en) begin
      if (hs_fall)
        h_nxt = '0;
      else if (h_cnt != 11'h7ff)
        h_nxt = h_cnt + 11'd1;
      if (vs_fall)
        v_nxt = '0;
      else if (hs_fall && v_cnt != 10'h3ff)
        v_nxt = v_cnt + 10'd1;
    end
  end

  // visibility of the current pixel and its write request
  always_comb begin
    vis = (h_nxt >= HS0) && (h_nxt < HE)
       && (v_nxt >= VS0) && (v_nxt < VE);
    wr_en_n = (state == CAPTURE) && pix_en
           && vis && !last_wr;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state and status outputs
  always_comb begin
    state_n    = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = ARMED;
      ARMED: begin
        busy = 1'b1;
        if (vs_fall) state_n = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (last_wr) state_n = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // sync sampling, counters, write port and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_hs  <= 1'b1;
      prev_vs  <= 1'b1;
      h_cnt    <= '0;
      v_cnt    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      sync_err <= 1'b0;
    end else begin
      if (pix_en) begin
        prev_hs <= h_sync;
        prev_vs <= v_sync;
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
      end
      wr_en <= wr_en_n;
      if (wr_en_n) wr_data <= rgb;
      if (state == ARMED && vs_fall)
        wr_addr <= '0;
      else if (state == CAPTURE) begin
        if (last_wr || vs_fall)
          wr_addr <= '0;
        else if (wr_en)
          wr_addr <= wr_addr + 1'b1;
      end
      if (state == IDLE && start)
        sync_err <= 1'b0;
      else if (state == CAPTURE && hs_fall && h_cnt != HL)
        sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed scenarios on a reduced raster
// (8x4 visible, 16x9 total) so each frame is a few hundred clocks.
module tb_vga_frame_capture;

  localparam int HA = 8;
  localparam int HST = 5;
  localparam int HT = 16;
  localparam int VA = 4;
  localparam int VST = 3;
  localparam int VT = 9;
  localparam int HSW = 2;
  localparam int VSW = 2;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic        h_sync = 1'b1;
  logic        v_sync = 1'b1;
  logic [7:0]  rgb = 8'd0;
  logic        start = 1'b0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;
  logic        sync_err;

  int n_checks = 0;
  int n_fail = 0;

  vga_frame_capture #(
    .H_ACTIVE(HA), .H_START(HST), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_START(VST), .ADDR_W(19)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_sync(h_sync), .v_sync(v_sync), .rgb(rgb),
    .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int wcount, dcount, seq_bad, out_bad;
  int cyc, last_we_cyc, done_cyc;
  logic pe_q = 1'b0;
  logic [7:0] mem [NPIX];

  always @(posedge clk) pe_q <= pix_en;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      if (int'(wr_addr) != wcount) seq_bad <= seq_bad + 1;
      if (!busy || !pe_q) out_bad <= out_bad + 1;
      if (int'(wr_addr) < NPIX) mem[int'(wr_addr)] <= wr_data;
      wcount <= wcount + 1;
      last_we_cyc <= cyc;
    end
    if (frame_done) begin
      dcount <= dcount + 1;
      done_cyc <= cyc;
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    wcount = 0; dcount = 0; seq_bad = 0; out_bad = 0;
    last_we_cyc = -10; done_cyc = -20;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'hff;
  endtask

  function automatic int mem_errs();
    int e = 0;
    for (int a = 0; a < NPIX; a++)
      if (mem[a] !== 8'((a % HA) + (a / HA))) e++;
    return e;
  endfunction

  task automatic tick(input logic hs, input logic vs,
                      input logic [7:0] d);
    @(negedge clk);
    pix_en = 1'b1; h_sync = hs; v_sync = vs; rgb = d;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic send_frame(input int short_l, input int pause_l);
    for (int l = 0; l < VT; l++) begin
      int len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        logic v;
        logic [7:0] d;
        if (l == pause_l && p == 8) repeat (10) @(negedge clk);
        v = (p >= HST) && (p < HST + HA)
         && (l >= VST) && (l < VST + VA);
        d = v ? 8'((p - HST) + (l - VST)) : 8'hee;
        tick(p >= HSW, l >= VSW, d);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks += 6;
    if (wr_en !== 1'b0) begin n_fail++;
      $display("FAIL reset wr_en: got %b want 0", wr_en); end
    if (wr_addr !== 19'd0) begin n_fail++;
      $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
    if (wr_data !== 8'd0) begin n_fail++;
      $display("FAIL reset wr_data: got %0d want 0", wr_data); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin n_fail++;
      $display("FAIL reset frame_done: got %b want 0", frame_done); end
    if (sync_err !== 1'b0) begin n_fail++;
      $display("FAIL reset sync_err: got %b want 0", sync_err); end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    pulse_start();
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++;
      $display("FAIL armed busy: got %b want 1", busy); end
    clear_mon();
    send_frame(-1, -1);
    #1;
    n_checks += 9;
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL full count: got %0d want %0d", wcount, NPIX); end
    if (mem[0] !== 8'd0) begin n_fail++;
      $display("FAIL full first: got %0d want 0", mem[0]); end
    if (mem[NPIX-1] !== 8'd10) begin n_fail++;
      $display("FAIL full last: got %0d want 10", mem[NPIX-1]); end
    if (mem_errs() != 0) begin n_fail++;
      $display("FAIL full data: got %0d bad want 0", mem_errs()); end
    if (seq_bad != 0) begin n_fail++;
      $display("FAIL full addr order: got %0d bad want 0", seq_bad); end
    if (out_bad != 0) begin n_fail++;
      $display("FAIL full stray wr_en: got %0d want 0", out_bad); end
    if (dcount != 1) begin n_fail++;
      $display("FAIL full done count: got %0d want 1", dcount); end
    if (done_cyc != last_we_cyc + 1) begin n_fail++;
      $display("FAIL full done latency: got %0d want %0d",
               done_cyc, last_we_cyc + 1); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL full busy: got %b want 0", busy); end
  endtask

  task automatic test_mid_frame_start();
    clear_mon();
    fork
      send_frame(-1, -1);
      begin repeat (130) @(negedge clk); pulse_start(); end
    join
    #1;
    n_checks += 2;
    if (wcount != 0) begin n_fail++;
      $display("FAIL midstart early writes: got %0d want 0", wcount); end
    if (busy !== 1'b1) begin n_fail++;
      $display("FAIL midstart busy: got %b want 1", busy); end
    send_frame(-1, -1);
    #1;
    n_checks += 4;
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL midstart count: got %0d want %0d", wcount, NPIX); end
    if (mem[0] !== 8'd0) begin n_fail++;
      $display("FAIL midstart first: got %0d want 0", mem[0]); end
    if (mem_errs() != 0 || seq_bad != 0) begin n_fail++;
      $display("FAIL midstart data: got %0d/%0d bad want 0",
               mem_errs(), seq_bad); end
    if (dcount != 1) begin n_fail++;
      $display("FAIL midstart done: got %0d want 1", dcount); end
  endtask

  task automatic test_sync_err();
    pulse_start();
    clear_mon();
    send_frame(5, -1);
    #1;
    n_checks += 4;
    if (sync_err !== 1'b1) begin n_fail++;
      $display("FAIL syncerr set: got %b want 1", sync_err); end
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL syncerr count: got %0d want %0d", wcount, NPIX); end
    if (dcount != 1) begin n_fail++;
      $display("FAIL syncerr done: got %0d want 1", dcount); end
    if (mem_errs() != 0) begin n_fail++;
      $display("FAIL syncerr data: got %0d bad want 0", mem_errs()); end
    pulse_start();
    #1;
    n_checks++;
    if (sync_err !== 1'b0) begin n_fail++;
      $display("FAIL syncerr clear: got %b want 0", sync_err); end
    clear_mon();
    send_frame(-1, -1);
    #1;
    n_checks += 2;
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL syncerr recount: got %0d want %0d", wcount, NPIX); end
    if (sync_err !== 1'b0) begin n_fail++;
      $display("FAIL syncerr clean: got %b want 0", sync_err); end
  endtask

  task automatic test_double_start();
    pulse_start();
    clear_mon();
    fork
      send_frame(-1, -1);
      begin repeat (100) @(negedge clk); pulse_start(); end
    join
    #1;
    n_checks += 3;
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL dblstart count: got %0d want %0d", wcount, NPIX); end
    if (dcount != 1) begin n_fail++;
      $display("FAIL dblstart done: got %0d want 1", dcount); end
    if (busy !== 1'b0) begin n_fail++;
      $display("FAIL dblstart busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int w0 = 0;
    pulse_start();
    clear_mon();
    fork
      send_frame(-1, -1);
      begin
        int k = 0;
        while (k < 2000 && wcount < 10) begin
          @(posedge clk); k++;
        end
        n_checks++;
        if (wcount < 10) begin n_fail++;
          $display("FAIL rstmid timeout: got %0d want 10", wcount); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        n_checks += 4;
        if (wr_en !== 1'b0) begin n_fail++;
          $display("FAIL rstmid wr_en: got %b want 0", wr_en); end
        if (busy !== 1'b0) begin n_fail++;
          $display("FAIL rstmid busy: got %b want 0", busy); end
        if (wr_addr !== 19'd0) begin n_fail++;
          $display("FAIL rstmid wr_addr: got %0d want 0", wr_addr); end
        if (frame_done !== 1'b0) begin n_fail++;
          $display("FAIL rstmid done: got %b want 0", frame_done); end
        w0 = wcount;
        rst = 1'b0;
      end
    join
    #1;
    n_checks += 2;
    if (wcount != w0) begin n_fail++;
      $display("FAIL rstmid late writes: got %0d want %0d", wcount, w0); end
    if (dcount != 0) begin n_fail++;
      $display("FAIL rstmid partial done: got %0d want 0", dcount); end
    pulse_start();
    clear_mon();
    send_frame(-1, -1);
    #1;
    n_checks += 2;
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL rstmid recount: got %0d want %0d", wcount, NPIX); end
    if (mem_errs() != 0 || dcount != 1) begin n_fail++;
      $display("FAIL rstmid recapture: got %0d bad, %0d done want 0, 1",
               mem_errs(), dcount); end
  endtask

  task automatic test_pause();
    pulse_start();
    clear_mon();
    send_frame(-1, 4);
    #1;
    n_checks += 4;
    if (wcount != NPIX) begin n_fail++;
      $display("FAIL pause count: got %0d want %0d", wcount, NPIX); end
    if (mem_errs() != 0) begin n_fail++;
      $display("FAIL pause data: got %0d bad want 0", mem_errs()); end
    if (seq_bad != 0 || out_bad != 0) begin n_fail++;
      $display("FAIL pause addr/stray: got %0d/%0d want 0",
               seq_bad, out_bad); end
    if (dcount != 1) begin n_fail++;
      $display("FAIL pause done: got %0d want 1", dcount); end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_full_frame();
    test_mid_frame_start();
    test_sync_err();
    test_double_start();
    test_reset_mid();
    test_pause();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
